character_anim_fsm: RTL

Sprite-state generator for the player character. It turns physics and input status into the `char_id` / `char_face` pair consumed by `character_display_controller`, so it sits on the producer side of that interface. All state changes are committed only on a frame tick, so the displayed sprite never changes mid-frame. An airborne debounce stops sprite flicker at platform edges.

---
 rtl/character_anim_fsm_pkg.sv | 13 +
 rtl/character_anim_fsm_frame_debounce.sv | 18 +
 rtl/character_anim_fsm.sv | 98 +++++++++
 3 files changed

// File: rtl/character_anim_fsm_pkg.sv
// character_anim_fsm_pkg: sprite codes and facing constants shared with character_display_controller
package character_anim_fsm_pkg;
  typedef enum logic [2:0] {
    IDLE_DIS_1         = 3'd0,
    IDLE_DIS_2         = 3'd1,
    CHARGE_DIS         = 3'd2,
    JUMP_UP_DIS        = 3'd3,
    JUMP_DOWN_DIS      = 3'd4,
    FALL_TO_GROUND_DIS = 3'd5
  } char_id_e;
  localparam logic signed [1:0] FACE_RIGHT = 2'sb01;
  localparam logic signed [1:0] FACE_LEFT  = 2'sb11;
endpackage

// File: rtl/character_anim_fsm_frame_debounce.sv
// frame_debounce: saturating count of consecutive frame ticks on which level is high
module frame_debounce #(
  parameter int MAX = 2,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic level,
  output logic hit
);
  localparam logic [W-1:0] TOP = W'(MAX);
  logic [W-1:0] cnt_q, cnt_d;
  // hit looks at the post-tick count so a qualifying tick takes effect on that same tick
  always_comb cnt_d = !tick ? cnt_q : !level ? '0 : (cnt_q == TOP) ? cnt_q : cnt_q + 1'b1;
  assign hit = cnt_d == TOP;
  always_ff @(posedge clk) cnt_q <= !rst_n ? '0 : cnt_d;
endmodule

// File: rtl/character_anim_fsm.sv
// character_anim_fsm: turns physics/input status into frame-synchronous sprite id and facing
module character_anim_fsm
  import character_anim_fsm_pkg::*;
#(
  parameter int VEL_WIDTH          = 8,
  parameter int IDLE_TOGGLE_FRAMES = 30,
  parameter int LAND_HOLD_FRAMES   = 8,
  parameter int AIR_DEBOUNCE       = 2
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic                        frame_tick,
  input  logic                        on_ground,
  input  logic                        charging,
  input  logic signed [VEL_WIDTH-1:0] vel_y,
  input  logic                        dir_left,
  input  logic                        dir_right,
  output logic [2:0]                  char_id,
  output logic signed [1:0]           char_face,
  output logic                        char_update
);
  localparam int LW = $clog2(LAND_HOLD_FRAMES) + 1;
  localparam int IW = $clog2(IDLE_TOGGLE_FRAMES) + 1;
  localparam logic [LW-1:0] LAND_LOAD = LW'(LAND_HOLD_FRAMES - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TOGGLE_FRAMES - 1);
  char_id_e id_q, id_d;
  logic signed [1:0] face_q, face_d;
  logic [LW-1:0] land_q, land_d;
  logic [IW-1:0] idle_q, idle_d;
  logic upd_q, upd_d;
  logic airborne;
  frame_debounce #(.MAX(AIR_DEBOUNCE)) u_air (
    .clk  (sys_clk),
    .rst_n(sys_rst_n),
    .tick (frame_tick),
    .level(!on_ground),
    .hit  (airborne)
  );
  always_comb begin
    id_d   = id_q;
    face_d = face_q;
    land_d = land_q;
    idle_d = idle_q;
    if (frame_tick) begin
      if (airborne) begin
        id_d = (vel_y < 0) ? JUMP_UP_DIS : JUMP_DOWN_DIS;
      end else begin
        face_d = (dir_right && !dir_left) ? FACE_RIGHT : (dir_left && !dir_right) ? FACE_LEFT : face_q;
        if (id_q == JUMP_UP_DIS || id_q == JUMP_DOWN_DIS) begin
          id_d   = FALL_TO_GROUND_DIS;
          land_d = LAND_LOAD;
        end else if (on_ground && charging) begin
          id_d = CHARGE_DIS;
        end else begin
          case (id_q)
            CHARGE_DIS: begin
              id_d   = charging ? CHARGE_DIS : IDLE_DIS_1;
              idle_d = charging ? idle_q : '0;
            end
            FALL_TO_GROUND_DIS: begin
              id_d   = (land_q == '0) ? IDLE_DIS_1 : FALL_TO_GROUND_DIS;
              land_d = (land_q == '0) ? land_q : land_q - 1'b1;
              idle_d = (land_q == '0) ? '0 : idle_q;
            end
            IDLE_DIS_1, IDLE_DIS_2: begin
              id_d   = (idle_q != IDLE_LAST) ? id_q : (id_q == IDLE_DIS_1) ? IDLE_DIS_2 : IDLE_DIS_1;
              idle_d = (idle_q == IDLE_LAST) ? '0 : idle_q + 1'b1;
            end
            JUMP_UP_DIS, JUMP_DOWN_DIS: id_d = id_q;
            default: begin
              id_d   = IDLE_DIS_1;
              idle_d = '0;
            end
          endcase
        end
      end
    end
    upd_d = frame_tick && (id_d != id_q || face_d != face_q);
  end
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      id_q   <= IDLE_DIS_1;
      face_q <= FACE_RIGHT;
      land_q <= '0;
      idle_q <= '0;
      upd_q  <= 1'b0;
    end else begin
      id_q   <= id_d;
      face_q <= face_d;
      land_q <= land_d;
      idle_q <= idle_d;
      upd_q  <= upd_d;
    end
  end
  assign char_id     = id_q;
  assign char_face   = face_q;
  assign char_update = upd_q;
endmodule
